fl_div_seq: RTL and testbench

FL_DIV_SEQ -- requirements
Module: fl_div_seq

---
 rtl/fl_pkg.sv | 13 +
 rtl/fl_div_step.sv | 44 ++++
 rtl/fl_div_seq.sv | 124 ++++++++++++
 tb/tb_fl_div_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fl_pkg.sv
// Shared float package: default word format and divider FSM state encoding.
package fl_pkg;

    localparam int unsigned EXP_DEF = 8;
    localparam int unsigned MAN_DEF = 23;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/fl_div_step.sv
// Restoring-division datapath: holds remainder, divisor and quotient, and
// produces one quotient bit per enabled cycle.
module fl_div_step
    import fl_pkg::*;
#(
    parameter int unsigned MAN = MAN_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           en,
    input  logic [MAN-1:0] m1,
    input  logic [MAN-1:0] m2,
    output logic [MAN-1:0] q
);

    logic [MAN:0]   r;
    logic [MAN-1:0] d;
    logic           qbit_c;
    logic [MAN-1:0] rem_c;

    // Remainder after a conditional subtract is always below the divisor,
    // so its top bit is dropped before the shift.
    always_comb begin
        qbit_c = (r >= {1'b0, d});
        rem_c  = qbit_c ? MAN'(r - {1'b0, d}) : r[MAN-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r <= '0;
            d <= '0;
            q <= '0;
        end else if (load) begin
            r <= {1'b0, m1};
            d <= m2;
            q <= '0;
        end else if (en) begin
            r <= {rem_c, 1'b0};
            q <= {q[MAN-2:0], qbit_c};
        end
    end

endmodule

// File: rtl/fl_div_seq.sv
// Sequential floating-point divider: one quotient bit per cycle, unnormalized
// result with exponent saturation and divide-by-zero flagging.
module fl_div_seq
    import fl_pkg::*;
#(
    parameter int unsigned EXP = EXP_DEF,
    parameter int unsigned MAN = MAN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAN+EXP:0]   in1,
    input  logic [MAN+EXP:0]   in2,
    output logic               busy,
    output logic               done,
    output logic [MAN+EXP:0]   out,
    output logic               dz,
    output logic               ovf
);

    localparam int unsigned W  = MAN + EXP + 1;
    localparam int unsigned CW = $clog2(MAN + 1);
    localparam int unsigned EW = EXP + 2;
    localparam logic signed [EW-1:0] E_HI = EW'((2 ** (EXP - 1)) - 1);
    localparam logic signed [EW-1:0] E_LO = ~E_HI;

    div_state_t             state;
    logic [CW-1:0]          cnt;
    logic                   s_r;
    logic                   dz_r;
    logic [EXP-1:0]         e1_r;
    logic [EXP-1:0]         e2_r;
    logic [MAN-1:0]         q;
    logic                   load_c;
    logic                   step_c;
    logic                   m2_zero_c;
    logic signed [EW-1:0]   e_calc_c;
    logic [W-1:0]           res_c;
    logic                   ovf_c;

    assign m2_zero_c = (in2[MAN-1:0] == '0);
    assign load_c    = (state == ST_IDLE) && start;
    assign step_c    = (state == ST_RUN) && (cnt != CW'(MAN)) && !dz_r;

    fl_div_step #(
        .MAN (MAN)
    ) u_step (
        .clk  (clk),
        .rst  (rst),
        .load (load_c),
        .en   (step_c),
        .m1   (in1[MAN-1:0]),
        .m2   (in2[MAN-1:0]),
        .q    (q)
    );

    // Exponent widened by two bits so the difference never wraps.
    assign e_calc_c = {{2{e1_r[EXP-1]}}, e1_r} - {{2{e2_r[EXP-1]}}, e2_r} - EW'(MAN - 1);

    always_comb begin
        res_c = {s_r, e_calc_c[EXP-1:0], q};
        ovf_c = 1'b0;
        if (dz_r) begin
            res_c = {s_r, E_HI[EXP-1:0], {MAN{1'b1}}};
        end else if (e_calc_c > E_HI) begin
            res_c = {s_r, E_HI[EXP-1:0], {MAN{1'b1}}};
            ovf_c = 1'b1;
        end else if (e_calc_c < E_LO) begin
            res_c = {s_r, E_LO[EXP-1:0], {MAN{1'b0}}};
        end
    end

    // Divide-by-zero presets the counter so RUN lasts two cycles with no steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            s_r   <= 1'b0;
            dz_r  <= 1'b0;
            e1_r  <= '0;
            e2_r  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        s_r   <= in1[W-1] ^ in2[W-1];
                        e1_r  <= in1[W-2:MAN];
                        e2_r  <= in2[W-2:MAN];
                        dz_r  <= m2_zero_c;
                        cnt   <= m2_zero_c ? CW'(MAN - 1) : '0;
                    end
                end
                ST_RUN: begin
                    if (cnt == CW'(MAN)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        out   <= res_c;
                        dz    <= dz_r;
                        ovf   <= ovf_c;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fl_div_seq.sv
// Bench for fl_div_seq: arithmetic reference model plus a per-cycle compare of
// busy, done and the held result.
module tb_fl_div_seq;

    localparam int EXP   = 8;
    localparam int MAN   = 23;
    localparam int W     = MAN + EXP + 1;
    localparam int E_MAX = 2 ** (EXP - 1) - 1;
    localparam int E_MIN = -(2 ** (EXP - 1));
    localparam int LAT   = MAN + 1;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] in1   = '0;
    logic [W-1:0] in2   = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         dz;
    logic         ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model of what the DUT should show: the op in flight and the result held before it.
    bit           have_acc = 1'b0;
    int           acc_edge = 0;
    int           lat      = 0;
    logic [W+1:0] res      = '0;
    logic [W+1:0] held     = '0;

    fl_div_seq #(.EXP(EXP), .MAN(MAN)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .dz    (dz),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int sext(input logic [EXP-1:0] v);
        return v[EXP-1] ? int'(v) - 2 ** EXP : int'(v);
    endfunction

    // Returns {out, dz, ovf} from the value rules of the format.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic            s;
        int              e;
        longint unsigned m1, m2, q;
        logic [MAN-1:0]  mf;
        s  = a[W-1] ^ b[W-1];
        m1 = 64'(a[MAN-1:0]);
        m2 = 64'(b[MAN-1:0]);
        e  = sext(a[W-2:MAN]) - sext(b[W-2:MAN]) - MAN + 1;
        if (m2 == 0) return {s, EXP'(E_MAX), {MAN{1'b1}}, 1'b1, 1'b0};
        q  = (m1 << (MAN - 1)) / m2;
        mf = q[MAN-1:0];
        if (e > E_MAX) return {s, EXP'(E_MAX), {MAN{1'b1}}, 1'b0, 1'b1};
        if (e < E_MIN) return {s, EXP'(E_MIN), {MAN{1'b0}}, 2'b00};
        return {s, EXP'(e), mf, 2'b00};
    endfunction

    function automatic logic [W-1:0] rand_op(input bit allow_zero);
        logic [EXP-1:0] ex;
        logic [MAN-1:0] mm;
        if ($urandom_range(0, 7) == 0) ex = EXP'($urandom);
        else ex = EXP'(int'($urandom_range(0, 80)) - 40);
        mm = MAN'($urandom);
        mm[MAN-1] = 1'b1;
        if (allow_zero && $urandom_range(0, 11) == 0) mm = '0;
        return {1'($urandom), ex, mm};
    endfunction

    // Per-cycle compare against the model.
    always @(negedge clk) begin : cmp
        logic [W+1:0] e_res;
        logic         e_busy;
        logic         e_done;
        if (rst) begin
            e_busy = 1'b0;
            e_done = 1'b0;
            e_res  = '0;
        end else if (!have_acc) begin
            e_busy = 1'b0;
            e_done = 1'b0;
            e_res  = held;
        end else begin
            e_busy = (cyc <= acc_edge + lat);
            e_done = (cyc == acc_edge + lat);
            e_res  = (cyc >= acc_edge + lat) ? res : held;
        end
        chk("busy", 64'(busy), 64'(e_busy));
        chk("done", 64'(done), 64'(e_done));
        chk("result{out,dz,ovf}", 64'({out, dz, ovf}), 64'(e_res));
    end

    // Waits until idle, then presents one request that the DUT must accept.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        while (have_acc && cyc <= acc_edge + lat) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        held     = have_acc ? res : held;
        res      = model(a, b);
        lat      = (b[MAN-1:0] == '0) ? 2 : LAT;
        acc_edge = cyc;
        have_acc = 1'b1;
    endtask

    // Start pulses that land while RUN is in progress.
    task automatic poke_run();
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        in1   = rand_op(1'b1);
        in2   = rand_op(1'b1);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Start pulse held exactly during the DONE cycle.
    task automatic poke_done();
        while (cyc < acc_edge + lat) begin
            @(posedge clk);
            #1;
        end
        start = 1'b1;
        in1   = rand_op(1'b1);
        in2   = rand_op(1'b1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    logic [W-1:0] d_a   [6];
    logic [W-1:0] d_b   [6];
    logic [W+1:0] d_exp [6];

    initial begin
        d_a[0] = {1'b0, 8'hEC, 23'h600000}; d_b[0] = {1'b0, 8'hEB, 23'h400000};
        d_exp[0] = {1'b0, 8'hEB, 23'h600000, 2'b00};
        d_a[1] = {1'b0, 8'hEA, 23'h400000}; d_b[1] = {1'b1, 8'hEB, 23'h600000};
        d_exp[1] = {1'b1, 8'hE9, 23'h2AAAAA, 2'b00};
        d_a[2] = {1'b0, 8'h10, 23'h500000}; d_b[2] = {1'b1, 8'h05, 23'h000000};
        d_exp[2] = {1'b1, 8'h7F, 23'h7FFFFF, 2'b10};
        d_a[3] = {1'b0, 8'h7F, 23'h400000}; d_b[3] = {1'b0, 8'h80, 23'h400000};
        d_exp[3] = {1'b0, 8'h7F, 23'h7FFFFF, 2'b01};
        d_a[4] = {1'b0, 8'h80, 23'h400000}; d_b[4] = {1'b0, 8'h7F, 23'h400000};
        d_exp[4] = {1'b0, 8'h80, 23'h000000, 2'b00};
        d_a[5] = {1'b0, 8'h10, 23'h000000}; d_b[5] = {1'b0, 8'h00, 23'h400000};
        d_exp[5] = {1'b0, 8'hFA, 23'h000000, 2'b00};

        #1 rst = 1'b1;
        #2;
        chk("reset_state", 64'({busy, done, out, dz, ovf}), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            chk($sformatf("model_pin%0d", i), 64'(model(d_a[i], d_b[i])), 64'(d_exp[i]));
            issue(d_a[i], d_b[i]);
            if (i == 1) poke_run();
            if (i == 2) poke_done();
        end

        // Abort after ten iterations, with stray starts during RUN.
        issue(d_a[0], d_b[0]);
        poke_run();
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        have_acc = 1'b0;
        held     = '0;
        #1;
        chk("async_rst_clear", 64'({busy, done, out, dz, ovf}), 64'(0));
        @(posedge clk);
        #2 rst = 1'b0;
        issue(d_a[0], d_b[0]);

        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            a = rand_op(1'b1);
            b = rand_op(1'b1);
            issue(a, b);
            if (lat == LAT && $urandom_range(0, 3) == 0) poke_run();
            if ($urandom_range(0, 3) == 0) poke_done();
            else repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        while (have_acc && cyc <= acc_edge + lat + 1) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
